// File: rtl/ext_mem_model.sv
// Behavioural external memory: one outstanding request, byte-masked writes,
// and read responses delivered a fixed number of cycles after acceptance.
module ext_mem_model #(
  parameter int MEM_ADDR_BITS = 28,
  parameter int MEM_DATA_BITS = 128,
  parameter int MEM_TAG_BITS  = 5,
  parameter int RAM_ADDR_BITS = 14,
  parameter int READ_LATENCY  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_req_valid,
  output logic                       mem_req_ready,
  input  logic                       mem_req_rw,
  input  logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
  input  logic [MEM_TAG_BITS-1:0]    mem_req_tag,
  input  logic                       mem_req_data_valid,
  output logic                       mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                       mem_resp_valid,
  output logic [MEM_TAG_BITS-1:0]    mem_resp_tag,
  output logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

  localparam int MASK_BITS = MEM_DATA_BITS / 8;

  typedef enum logic [1:0] {IDLE, WRITE_DATA, READ_WAIT} state_t;

  state_t                     state_q, state_d;
  logic                       req_ready_q, req_ready_d;
  logic                       data_ready_q, data_ready_d;
  logic                       resp_valid_q, resp_valid_d;
  logic [MEM_TAG_BITS-1:0]    resp_tag_q, resp_tag_d;
  logic [MEM_DATA_BITS-1:0]   resp_data_q, resp_data_d;
  logic [RAM_ADDR_BITS-1:0]   addr_q, addr_d;
  logic [MEM_TAG_BITS-1:0]    tag_q, tag_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       wr_en;

  logic [MEM_DATA_BITS-1:0] ram [0:(1<<RAM_ADDR_BITS)-1];

  // Upper address bits alias onto the same storage.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_req_addr[MEM_ADDR_BITS-1:RAM_ADDR_BITS];

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    data_ready_d = data_ready_q;
    resp_valid_d = 1'b0;
    resp_tag_d   = resp_tag_q;
    resp_data_d  = resp_data_q;
    addr_d       = addr_q;
    tag_d        = tag_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (mem_req_valid && req_ready_q) begin
          addr_d      = mem_req_addr[RAM_ADDR_BITS-1:0];
          tag_d       = mem_req_tag;
          req_ready_d = 1'b0;
          if (mem_req_rw) begin
            state_d      = WRITE_DATA;
            data_ready_d = 1'b1;
          end else begin
            state_d = READ_WAIT;
            cnt_d   = 4'(READ_LATENCY);
          end
        end
      end
      WRITE_DATA: begin
        if (mem_req_data_valid) begin
          state_d      = IDLE;
          data_ready_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      READ_WAIT: begin
        // cnt==1 launches the response; cnt==0 is the response cycle itself.
        if (cnt_q == 4'd1) begin
          resp_valid_d = 1'b1;
          resp_tag_d   = tag_q;
          resp_data_d  = ram[addr_q];
          cnt_d        = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      data_ready_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
      resp_data_q  <= '0;
      addr_q       <= '0;
      tag_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      data_ready_q <= data_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_tag_q   <= resp_tag_d;
      resp_data_q  <= resp_data_d;
      addr_q       <= addr_d;
      tag_q        <= tag_d;
      cnt_q        <= cnt_d;
    end
  end

  assign wr_en = (state_q == WRITE_DATA) && mem_req_data_valid;

  // Storage is deliberately outside the reset domain so reset never disturbs it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < MASK_BITS; i++) begin
        if (mem_req_data_mask[i]) ram[addr_q][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
      end
    end
  end

  assign mem_req_ready      = req_ready_q;
  assign mem_req_data_ready = data_ready_q;
  assign mem_resp_valid     = resp_valid_q;
  assign mem_resp_tag       = resp_tag_q;
  assign mem_resp_data      = resp_data_q;

endmodule

// File: tb/tb_ext_mem_model.sv
// Directed bench for ext_mem_model: table of write/read transactions plus
// hand-written sequences for back-to-back reads and reset mid-operation.
module tb_ext_mem_model;

  localparam int LAT = 2;

  logic         clk;
  logic         reset;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic [4:0]   mem_req_tag;
  logic         mem_req_data_valid;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [4:0]   mem_resp_tag;
  logic [127:0] mem_resp_data;

  int n_compared = 0;
  int n_mismatch = 0;

  ext_mem_model #(
    .MEM_ADDR_BITS(28), .MEM_DATA_BITS(128), .MEM_TAG_BITS(5),
    .RAM_ADDR_BITS(14), .READ_LATENCY(LAT)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_rw         (mem_req_rw),
    .mem_req_addr       (mem_req_addr),
    .mem_req_tag        (mem_req_tag),
    .mem_req_data_valid (mem_req_data_valid),
    .mem_req_data_ready (mem_req_data_ready),
    .mem_req_data_bits  (mem_req_data_bits),
    .mem_req_data_mask  (mem_req_data_mask),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_tag       (mem_resp_tag),
    .mem_resp_data      (mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rw;
    logic [27:0]  addr;
    logic [4:0]   tag;
    logic [127:0] data;
    logic [15:0]  mask;
    int           delay;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [12];

  localparam logic [127:0] PRELOAD = 128'h00112233445566778899AABBCCDDEEFF;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Leaves the caller at a falling edge with mem_req_ready high.
  task automatic waitReady(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bit ok;
    int hits;
    int first;
    logic [4:0]   rtag;
    logic [127:0] rdata;
    waitReady(ok);
    if (!ok) begin
      checkOutput("ready_timeout", 128'd0, 128'd1);
      return;
    end
    checkOutput("data_ready_in_idle", 128'(mem_req_data_ready), 128'd0);
    mem_req_valid = 1'b1;
    mem_req_rw    = v.rw;
    mem_req_addr  = v.addr;
    mem_req_tag   = v.tag;
    @(posedge clk);
    #1 mem_req_valid = 1'b0;
    if (v.rw) begin
      for (int d = 0; d < v.delay; d++) begin
        @(negedge clk);
        checkOutput("wr_wait_req_ready", 128'(mem_req_ready), 128'd0);
        checkOutput("wr_wait_data_ready", 128'(mem_req_data_ready), 128'd1);
        checkOutput("wr_wait_resp_valid", 128'(mem_resp_valid), 128'd0);
      end
      @(negedge clk);
      checkOutput("wr_data_ready", 128'(mem_req_data_ready), 128'd1);
      mem_req_data_valid = 1'b1;
      mem_req_data_bits  = v.data;
      mem_req_data_mask  = v.mask;
      @(posedge clk);
      #1 mem_req_data_valid = 1'b0;
      @(negedge clk);
      checkOutput("wr_done_data_ready", 128'(mem_req_data_ready), 128'd0);
      checkOutput("wr_done_req_ready", 128'(mem_req_ready), 128'd1);
      checkOutput("wr_no_resp", 128'(mem_resp_valid), 128'd0);
    end else begin
      hits  = 0;
      first = -1;
      rtag  = '0;
      rdata = '0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (mem_resp_valid) begin
          hits++;
          if (hits == 1) begin
            first = c;
            rtag  = mem_resp_tag;
            rdata = mem_resp_data;
          end
        end
        if (c == LAT) checkOutput("rd_ready_in_resp", 128'(mem_req_ready), 128'd0);
        if (c == LAT + 1) checkOutput("rd_ready_after", 128'(mem_req_ready), 128'd1);
      end
      checkOutput("rd_resp_count", 128'(hits), 128'd1);
      checkOutput("rd_resp_latency", 128'(first), 128'(LAT));
      checkOutput("rd_resp_tag", 128'(rtag), 128'(v.tag));
      checkOutput("rd_resp_data", rdata, v.exp);
      checkOutput("rd_tag_held", 128'(mem_resp_tag), 128'(v.tag));
      checkOutput("rd_data_held", mem_resp_data, v.exp);
    end
  endtask

  function automatic vec_t mk(input logic rw, input logic [27:0] addr, input logic [4:0] tag,
                              input logic [127:0] data, input logic [15:0] mask,
                              input int delay, input logic [127:0] exp);
    vec_t v;
    v.rw = rw; v.addr = addr; v.tag = tag; v.data = data;
    v.mask = mask; v.delay = delay; v.exp = exp;
    return v;
  endfunction

  initial begin
    bit ok;
    int hits;
    int acc2;
    int rc [2];
    logic [4:0]   rt [2];
    logic [127:0] rd [2];

    vecs[0]  = mk(1'b1, 28'h0000005, 5'd0,  PRELOAD,        16'hFFFF, 0, '0);
    vecs[1]  = mk(1'b1, 28'h0000007, 5'd0,  128'd0,         16'hFFFF, 0, '0);
    vecs[2]  = mk(1'b0, 28'h0000005, 5'd3,  '0,             16'h0000, 0, PRELOAD);
    vecs[3]  = mk(1'b1, 28'h0000007, 5'd0,  {16{8'hAA}},    16'h00FF, 0, '0);
    vecs[4]  = mk(1'b0, 28'h0000007, 5'd4,  '0,             16'h0000, 0,
                  128'h0000000000000000AAAAAAAAAAAAAAAA);
    vecs[5]  = mk(1'b1, 28'h0004007, 5'd0,  128'd1,         16'hFFFF, 3, '0);
    vecs[6]  = mk(1'b0, 28'h0000007, 5'd5,  '0,             16'h0000, 0, 128'd1);
    vecs[7]  = mk(1'b1, 28'h0000007, 5'd0,  {16{8'hFF}},    16'h0000, 1, '0);
    vecs[8]  = mk(1'b0, 28'hABC8007, 5'd31, '0,             16'h0000, 0, 128'd1);
    vecs[9]  = mk(1'b1, 28'h0003FFF, 5'd0,  {16{8'h55}},    16'hFFFF, 0, '0);
    vecs[10] = mk(1'b1, 28'h0003FFF, 5'd0,  {16{8'hC3}},    16'hF00F, 2, '0);
    vecs[11] = mk(1'b0, 28'h0003FFF, 5'd17, '0,             16'h0000, 0,
                  128'hC3C3C3C35555555555555555C3C3C3C3 | 128'h0);

    // Correct the last expected value byte-exactly: bytes 15..12 and 3..0 are C3.
    vecs[11].exp = 128'hC3C3C3C3_55555555_55555555_C3C3C3C3;

    reset              = 1'b0;
    mem_req_valid      = 1'b0;
    mem_req_rw         = 1'b0;
    mem_req_addr       = '0;
    mem_req_tag        = '0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = '0;
    mem_req_data_mask  = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", 128'(mem_req_ready), 128'd0);
    checkOutput("rst_data_ready", 128'(mem_req_data_ready), 128'd0);
    checkOutput("rst_resp_valid", 128'(mem_resp_valid), 128'd0);
    checkOutput("rst_resp_tag", 128'(mem_resp_tag), 128'd0);
    checkOutput("rst_resp_data", mem_resp_data, 128'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_release", 128'(mem_req_ready), 128'd1);

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Back-to-back reads: second request is held pending while the first completes.
    waitReady(ok);
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 28'h5;
    mem_req_tag   = 5'd1;
    @(posedge clk);
    #1;
    mem_req_addr = 28'h7;
    mem_req_tag  = 5'd2;
    hits = 0;
    acc2 = -1;
    rc[0] = -1; rc[1] = -1;
    rt[0] = '0; rt[1] = '0;
    rd[0] = '0; rd[1] = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_resp_valid) begin
        if (hits < 2) begin
          rc[hits] = c;
          rt[hits] = mem_resp_tag;
          rd[hits] = mem_resp_data;
        end
        hits++;
      end
      if (mem_req_ready && mem_req_valid) begin
        acc2 = c;
        @(posedge clk);
        #1 mem_req_valid = 1'b0;
      end
    end
    mem_req_valid = 1'b0;
    checkOutput("b2b_second_accept", 128'(acc2), 128'(LAT + 1));
    checkOutput("b2b_resp_count", 128'(hits), 128'd2);
    checkOutput("b2b_resp0_cycle", 128'(rc[0]), 128'(LAT));
    checkOutput("b2b_resp1_cycle", 128'(rc[1]), 128'(2 * LAT + 2));
    checkOutput("b2b_resp0_tag", 128'(rt[0]), 128'd1);
    checkOutput("b2b_resp1_tag", 128'(rt[1]), 128'd2);
    checkOutput("b2b_resp0_data", rd[0], PRELOAD);
    checkOutput("b2b_resp1_data", rd[1], 128'd1);

    // Reset while a read is waiting: the read must never respond.
    waitReady(ok);
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 28'h5;
    mem_req_tag   = 5'd9;
    @(posedge clk);
    #1 mem_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midrd_rst_resp_valid", 128'(mem_resp_valid), 128'd0);
    checkOutput("midrd_rst_req_ready", 128'(mem_req_ready), 128'd0);
    checkOutput("midrd_rst_resp_tag", 128'(mem_resp_tag), 128'd0);
    checkOutput("midrd_rst_resp_data", mem_resp_data, 128'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    hits = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) checkOutput("midrd_ready_after", 128'(mem_req_ready), 128'd1);
      if (mem_resp_valid) hits++;
    end
    checkOutput("midrd_no_resp", 128'(hits), 128'd0);
    applyStimulus(mk(1'b0, 28'h5, 5'd10, '0, 16'h0, 0, PRELOAD));

    // Reset while a write waits for data; data offered later in IDLE is ignored.
    waitReady(ok);
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b1;
    mem_req_addr  = 28'h5;
    @(posedge clk);
    #1 mem_req_valid = 1'b0;
    @(negedge clk);
    reset              = 1'b0;
    mem_req_data_valid = 1'b1;
    mem_req_data_bits  = {16{8'hEE}};
    mem_req_data_mask  = 16'hFFFF;
    repeat (2) @(negedge clk);
    checkOutput("midwr_rst_data_ready", 128'(mem_req_data_ready), 128'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midwr_ready_after", 128'(mem_req_ready), 128'd1);
    checkOutput("idle_data_ready", 128'(mem_req_data_ready), 128'd0);
    mem_req_data_valid = 1'b0;
    applyStimulus(mk(1'b0, 28'h5, 5'd11, '0, 16'h0, 0, PRELOAD));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/ext_mem_model.md
EXT_MEM_MODEL -- requirements
Module: ext_mem_model

Interface
REQ-001 SHALL have parameter MEM_ADDR_BITS, default 28, line-address width (one address = one data beat).
REQ-002 SHALL have parameter MEM_DATA_BITS, default 128, data beat width in bits (16 bytes).
REQ-003 SHALL have parameter MEM_TAG_BITS, default 5, request/response tag width.
REQ-004 SHALL have parameter RAM_ADDR_BITS, default 14, log2 of storage depth in beats.
REQ-005 SHALL have parameter READ_LATENCY, default 2 (legal range 1..15), cycles from read acceptance to response.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1; one clock; reset is asynchronous and active-low.
REQ-008 SHALL have port mem_req_valid, input, 1, request present.
REQ-009 SHALL have port mem_req_ready, output, 1, request accepted when high with valid.
REQ-010 SHALL have port mem_req_rw, input, 1, 1 = write, 0 = read.
REQ-011 SHALL have port mem_req_addr, input, MEM_ADDR_BITS, beat address.
REQ-012 SHALL have port mem_req_tag, input, MEM_TAG_BITS, tag returned on read response.
REQ-013 SHALL have port mem_req_data_valid, input, 1, write data present.
REQ-014 SHALL have port mem_req_data_ready, output, 1, write data accepted when high with data_valid.
REQ-015 SHALL have port mem_req_data_bits, input, MEM_DATA_BITS, write data.
REQ-016 SHALL have port mem_req_data_mask, input, MEM_DATA_BITS/8, per-byte write enable.
REQ-017 SHALL have port mem_resp_valid, output, 1, read response present (single cycle).
REQ-018 SHALL have port mem_resp_tag, output, MEM_TAG_BITS, tag of responding read.
REQ-019 SHALL have port mem_resp_data, output, MEM_DATA_BITS, read data.

Function
REQ-020 SHALL store 2**RAM_ADDR_BITS beats of MEM_DATA_BITS in an array named ram, preloadable by $readmemh from outside (hierarchical name <inst>.ram).
REQ-021 SHALL index ram with mem_req_addr[RAM_ADDR_BITS-1:0]; upper address bits ignored (wrap-around aliasing).
REQ-022 SHALL implement FSM states IDLE, WRITE_DATA, READ_WAIT; one outstanding request at a time.
REQ-023 IDLE: mem_req_ready=1, mem_req_data_ready=0; other states: mem_req_ready=0.
REQ-024 Request accepted on rising edge with mem_req_valid & mem_req_ready; addr, tag, rw captured that edge.
REQ-025 Accepted write -> WRITE_DATA; mem_req_data_ready=1 there; write data never accepted in the request cycle.
REQ-026 WRITE_DATA: on edge with mem_req_data_valid, for each i with mask[i]=1 write byte bits[8i+7:8i] to ram; unmasked bytes unchanged; return to IDLE; no response for writes.
REQ-027 Mask all zero SHALL complete the handshake and leave ram unchanged.
REQ-028 Accepted read -> READ_WAIT; mem_resp_valid SHALL be 1 for exactly one cycle, beginning READ_LATENCY cycles after the accept edge, with mem_resp_tag = captured tag and mem_resp_data = ram contents at captured address.
REQ-029 Read data SHALL reflect all writes completed before the read was accepted.
REQ-030 After the response cycle the FSM returns to IDLE; next request may be accepted in the edge ending the response cycle is NOT allowed (ready rises the following cycle).
REQ-031 mem_resp_data and mem_resp_tag SHALL be registered and hold their last value when mem_resp_valid=0.
REQ-032 Inputs outside their handshake cycles SHALL be ignored (e.g. data_valid in IDLE, req_valid outside IDLE).

Reset
REQ-033 While reset=0: state IDLE, mem_req_ready=0, mem_req_data_ready=0, mem_resp_valid=0, mem_resp_tag=0, mem_resp_data=0, latency counter=0.
REQ-034 Reset asserted mid-operation SHALL abort the pending read (no response) or pending write (no ram update).
REQ-035 Reset SHALL NOT modify ram contents; mem_req_ready=1 from first edge after reset release.

Verification
REQ-036 Preload ram[5]=0x0011..FF; read addr 5 tag 3 -> resp_valid one cycle, 2 cycles after accept, tag 3, data 0x00112233445566778899AABBCCDDEEFF.
REQ-037 Write addr 7 data all 0xAA mask 0x00FF over ram[7]=0 -> read addr 7 returns 0x0000000000000000AAAAAAAAAAAAAAAA.
REQ-038 Write addr 0x4007 (RAM_ADDR_BITS=14) data 0x1 mask 0xFFFF -> read addr 7 returns 0x1 (aliasing).
REQ-039 Write request with data_valid delayed 3 cycles -> req_ready low, data_ready high until data accepted; no resp_valid.
REQ-040 Assert reset during READ_WAIT -> no resp_valid ever for that read; ram intact; req_ready=1 after release.
REQ-041 Back-to-back reads tags 1,2 -> two single-cycle responses in order, tags 1 then 2, ready low between accept and response.
